ram_port_arbiter: RTL
=====================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, RAM data width.
REQ-003 SHALL have parameter CPU_BURST_MAX, default 8, range 1-15: maximum consecutive CPU grants while the readout request waits.
REQ-004 SHALL have port clk  in  1  single clock; every register updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have CPU ports: cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_W, cpu_wdata in DATA_W, cpu_gnt out 1, cpu_rvalid out 1, cpu_rdata out DATA_W.
REQ-007 SHALL have readout ports: rd_req in 1, rd_addr in ADDR_W, rd_gnt out 1, rd_rvalid out 1, rd_rdata out DATA_W. The readout port is read-only.
REQ-008 SHALL have RAM ports: ram_en out 1, ram_we out 1, ram_addr out ADDR_W, ram_din out DATA_W, ram_dout in DATA_W. The RAM is single-port with 1-cycle read latency.

Function
REQ-009 SHALL grant at most one access per cycle. Grants are combinational from the current req inputs and registered state.
REQ-010 SHALL grant as follows when only one requester is active: that requester is granted.
REQ-011 SHALL grant as follows when cpu_req and rd_req are both 1: CPU wins if starve_cnt < CPU_BURST_MAX; otherwise readout wins.
REQ-012 SHALL update starve_cnt (4-bit) as follows:
- +1 on a CPU grant while rd_req=1;
- cleared on any rd grant or any cycle with rd_req=0;
- saturates at CPU_BURST_MAX.
REQ-013 SHALL drive the RAM from the granted requester in the same cycle:
- ram_en=1;
- ram_addr=granted address;
- ram_we=cpu_we for a CPU grant, 0 for a readout grant;
- ram_din=cpu_wdata.
REQ-014 SHALL drive ram_en=0, ram_we=0, ram_addr=0 and ram_din=0 when no grant is made.
REQ-015 SHALL require each requester to hold req, addr and (CPU only) we/wdata stable until its gnt cycle. One gnt completes one access. A req held after gnt is a new request.
REQ-016 SHALL keep a return-owner register with states:
- RET_NONE;
- RET_CPU, loaded on a CPU read grant (cpu_we=0);
- RET_RD, loaded on a readout grant;
- RET_NONE otherwise, including on CPU write grants.
REQ-017 SHALL assert cpu_rvalid=1 for exactly one cycle, the cycle after a CPU read grant (return-owner=RET_CPU). Likewise rd_rvalid=1 the cycle after a readout grant (RET_RD).
REQ-018 SHALL drive cpu_rdata=ram_dout when cpu_rvalid=1, else 0; rd_rdata=ram_dout when rd_rvalid=1, else 0.
REQ-019 SHALL generate no rvalid for CPU writes. cpu_gnt on a write is the completion.
REQ-020 SHALL allow back-to-back grants, to the same or alternating requesters, every cycle with no bubble. Read returns pipeline one cycle behind grants.
REQ-021 SHALL handle a read immediately following a write to the same address in the next cycle by returning the newly written data (RAM write-first behaviour is passed through; no bypass logic).

Reset
REQ-022 SHALL, while reset=1, drive:
- cpu_gnt=0 and rd_gnt=0;
- ram_en=0 and ram_we=0;
- ram_addr=0 and ram_din=0;
- rvalids=0.
REQ-023 SHALL, on the first clock edge with reset=1, clear starve_cnt to 0 and the return-owner to RET_NONE.
REQ-024 SHALL discard a read granted in the cycle before reset asserts: no rvalid is produced after reset.
REQ-025 SHALL issue grants in the first cycle after reset deasserts per REQ-010/011 with starve_cnt=0.

Verification
REQ-026 SHALL cover this scenario: cpu_req=1, cpu_we=1, addr=0x05, wdata=0xBEEF, then a CPU read of 0x05 -> write gnt with ram_we=1; read gnt; cpu_rvalid=1 the next cycle with cpu_rdata=0xBEEF.
REQ-027 SHALL cover this scenario: only rd_req=1, rd_addr=0x05 -> rd_gnt same cycle; rd_rvalid next cycle with rd_rdata=0xBEEF; cpu_rvalid stays 0.
REQ-028 SHALL cover this scenario: CPU_BURST_MAX=8, cpu_req and rd_req held 1 for 20 cycles -> pattern is 8 CPU grants, 1 rd grant, 8 CPU grants, 1 rd grant, and so on. starve_cnt never exceeds 8.
REQ-029 SHALL cover this scenario: alternating CPU read 0x01 and rd read 0x02 on consecutive cycles -> an rvalid every cycle, routed to the correct port with the correct data, no bubble.
REQ-030 SHALL cover this scenario: CPU read grant at cycle N, reset=1 at cycle N+1 -> cpu_rvalid=0 at N+1 and N+2; all outputs 0 during reset.
REQ-031 SHALL cover this scenario: no requests -> ram_en=0, ram_addr=0, gnts=0, starve_cnt=0.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the CPU, readout and RAM-side signals around the two-port RAM arbiter.
interface ram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
);
    // CPU port
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    // Read-only readout port
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_rvalid;
    logic [DATA_W-1:0] rd_rdata;

    // Single-port RAM, 1-cycle read latency
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  rd_req, rd_addr,
        output rd_gnt, rd_rvalid, rd_rdata,
        output ram_en, ram_we, ram_addr, ram_din,
        input  ram_dout
    );

    // Requesters plus RAM model side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output rd_req, rd_addr,
        input  rd_gnt, rd_rvalid, rd_rdata,
        input  ram_en, ram_we, ram_addr, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Arbitrates a CPU port and a read-only readout port onto one single-port RAM.
// CPU has priority but may take at most CPU_BURST_MAX grants in a row while
// the readout port is waiting. Grants are combinational; read data returns one
// cycle later to whichever port owned the read.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W        = 6,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned CPU_BURST_MAX = 8
) (
    input  logic               clk,
    input  logic               reset,
    ram_port_arbiter_if.slave  bus
);

    localparam int unsigned   CNT_W     = 4;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(CPU_BURST_MAX);

    typedef enum logic [1:0] {
        RET_NONE = 2'd0,
        RET_CPU  = 2'd1,
        RET_RD   = 2'd2
    } ret_e;

    logic [CNT_W-1:0] starve_q, starve_d;
    ret_e             ret_q, ret_d;
    logic             cpu_gnt_c, rd_gnt_c;

    // Grant selection: single requester wins; on contention CPU wins until its burst budget runs out
    always_comb begin
        cpu_gnt_c = 1'b0;
        rd_gnt_c  = 1'b0;
        if (!reset) begin
            if (bus.cpu_req && bus.rd_req) begin
                if (starve_q < BURST_MAX) begin
                    cpu_gnt_c = 1'b1;
                end else begin
                    rd_gnt_c = 1'b1;
                end
            end else if (bus.cpu_req) begin
                cpu_gnt_c = 1'b1;
            end else if (bus.rd_req) begin
                rd_gnt_c = 1'b1;
            end
        end
    end

    // RAM drive follows the granted requester in the same cycle; all zero when idle
    always_comb begin
        bus.ram_en   = 1'b0;
        bus.ram_we   = 1'b0;
        bus.ram_addr = '0;
        bus.ram_din  = '0;
        if (cpu_gnt_c) begin
            bus.ram_en   = 1'b1;
            bus.ram_we   = bus.cpu_we;
            bus.ram_addr = bus.cpu_addr;
            bus.ram_din  = bus.cpu_wdata;
        end else if (rd_gnt_c) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = bus.rd_addr;
            bus.ram_din  = bus.cpu_wdata;
        end
    end

    // Next starvation count and next return owner
    always_comb begin
        starve_d = starve_q;
        ret_d    = RET_NONE;
        if (rd_gnt_c || !bus.rd_req) begin
            starve_d = '0;
        end else if (cpu_gnt_c) begin
            starve_d = (starve_q >= BURST_MAX) ? BURST_MAX : starve_q + CNT_W'(1);
        end
        if (rd_gnt_c) begin
            ret_d = RET_RD;
        end else if (cpu_gnt_c && !bus.cpu_we) begin
            ret_d = RET_CPU;
        end
    end

    // State registers; reset also drops any read that was in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
            ret_q    <= RET_NONE;
        end else begin
            starve_q <= starve_d;
            ret_q    <= ret_d;
        end
    end

    // Grant and read-return outputs; returns are suppressed while reset is high
    assign bus.cpu_gnt    = cpu_gnt_c;
    assign bus.rd_gnt     = rd_gnt_c;
    assign bus.cpu_rvalid = !reset && (ret_q == RET_CPU);
    assign bus.rd_rvalid  = !reset && (ret_q == RET_RD);
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.ram_dout : '0;
    assign bus.rd_rdata   = bus.rd_rvalid  ? bus.ram_dout : '0;

endmodule
